dac_cmd_decoder: RTL and testbench
==================================

# dac_cmd_decoder

Receive side of the DAC programming link. Deserializes a framed serial command stream, decodes the 4-bit command code back to a 3-bit register address, and writes a 10-bit data word into an 8-entry shadow register bank. The bank is readable by the slow-control logic. Sits at the DAC/front-end end of the link, inverse to the command-code encoder on the controller side.

## Interface
Parameters:
- DATA_W, 10, width of the data field and of each shadow register.
- NREG, 8, number of shadow registers (fixed by the 3-bit address).

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-low.
- frame_n  in  1  frame enable, active low; a frame is one low period.
- bit_en  in  1  bit strobe; sdin is sampled when bit_en=1 and frame_n=0.
- sdin  in  1  serial data, MSB first.
- rd_addr  in  3  shadow register read address.
- rd_data  out  DATA_W  combinational read of shadow[rd_addr].
- wr_valid  out  1  one-cycle pulse: a frame was accepted and written.
- wr_addr  out  3  decoded address of the last accepted frame.
- wr_data  out  DATA_W  data of the last accepted frame.
- err  out  1  one-cycle pulse: a frame was rejected.
- err_code  out  2  reason for the last reject: 01 bad length, 10 bad code, 11 parity.

## Operation
- Frame layout, MSB first: code[3:0], then data[9:0], then a parity bit if enabled. Base length is 14 bits.
- Code map: code 2..9 gives addr = code−2 (0010→0, …, 1001→7). Codes 0, 1 and 10..15 are bad codes.
- State machine:
  - IDLE: shift register and bit counter are cleared. frame_n=0 goes to SHIFT; a bit may be sampled in the same cycle.
  - SHIFT: each qualified bit shifts into the shift register and increments the counter. The counter saturates at 15; bits beyond the frame length are not stored but still mark the frame overlong. frame_n=1 goes to CHECK.
  - CHECK, one cycle, evaluated in priority order:
    1. Counter ≠ frame length → err, err_code=01.
    2. Bad code → err, err_code=10.
    3. Parity fail → err, err_code=11.
    4. Otherwise: write shadow[addr], update wr_addr/wr_data, pulse wr_valid.
    - Then return to IDLE. If frame_n=0 already in CHECK, the new frame is entered through IDLE on the next cycle; bits strobed during CHECK are lost.
- A rejected frame leaves the shadow bank, wr_addr and wr_data unchanged.
- If rd_addr equals the address being written, rd_data shows the old value in the CHECK cycle and the new value from the next cycle.

## Timing
- Reset (async assert, sync release):
  - state IDLE.
  - wr_valid=0, err=0, err_code=00.
  - wr_addr=0, wr_data=0.
  - all shadow registers 0, so rd_data=0.
- Reset asserted mid-frame aborts the frame silently: no err pulse.
- Latency: frame_n rising edge seen at cycle N → wr_valid or err high in cycle N+1 for exactly one cycle. Shadow write and wr_addr/wr_data update land at the same clock edge.
- wr_valid and err are never high together.
- Minimum frame_n high time between frames: 1 cycle. A zero-bit frame (frame_n low with no bit_en) is a bad-length error.
- bit_en with frame_n=1 is ignored.

## Configuration
- DAC_DEC_PARITY_EN defined:
  - frame length is 15 bits; the last bit is even parity over the preceding 14 bits.
  - a mismatch gives err_code=11.
- Not defined:
  - frame length is 14 bits; there is no parity check.
  - err_code 11 is never produced.
  - a 15-bit frame is a bad-length error.

## Structure
- Shared package dac_link_pkg holds:
  - code constants DAC_CODE_MIN=4'h2 and DAC_CODE_MAX=4'h9;
  - DAC_ADDR_OFFSET=2;
  - frame length constants (14/15);
  - err_code localparams ERR_LEN, ERR_CODE, ERR_PAR.
- The controller-side encoder uses the same package.
- Sub-module dac_frame_shifter holds the shift register, saturating bit counter and running parity. It has a clear input driven from IDLE. The top level holds the FSM, decode and the shadow bank.

## Test plan
- Frame 0010_0000000001 (addr 0, data 1) → wr_valid one cycle after frame_n rises; wr_addr=0, wr_data=0x001; rd_addr=0 gives rd_data=0x001 on the following cycle.
- Eight frames, codes 2..9 with data 0x3FF, 0x155, … → shadow[0..7] hold the matching data; no err.
- Code 1010 with a valid length → err, err_code=10; shadow unchanged.
- 13-bit frame and 16-bit frame → err, err_code=01 each time; back-to-back valid frame with 1-cycle gap is accepted.
- Reset pulsed after 7 bits of a frame → no err or wr_valid; all outputs and shadow registers 0; the next full frame is accepted.
- With DAC_DEC_PARITY_EN: 15-bit frame with correct parity → accepted; flipped parity bit → err, err_code=11. Without the macro, the same 15-bit frame → err_code=01.

Source files
------------

// File: rtl/dac_link_pkg.sv
// Shared definitions for both ends of the DAC programming link (command encoder and decoder).
// Build option DAC_DEC_PARITY_EN appends an even-parity bit to every frame.
package dac_link_pkg;

   localparam int DAC_DATA_W         = 10;
   localparam int DAC_CODE_W         = 4;
   localparam logic [3:0] DAC_CODE_MIN = 4'h2;
   localparam logic [3:0] DAC_CODE_MAX = 4'h9;
   localparam int DAC_ADDR_OFFSET    = 2;
   localparam int DAC_FRAME_LEN_BASE = 14;
   localparam int DAC_FRAME_LEN_PAR  = 15;

`ifdef DAC_DEC_PARITY_EN
   localparam int DAC_PAR_BITS  = 1;
   localparam int DAC_FRAME_LEN = DAC_FRAME_LEN_PAR;
`else
   localparam int DAC_PAR_BITS  = 0;
   localparam int DAC_FRAME_LEN = DAC_FRAME_LEN_BASE;
`endif

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CODE = 2'b10;
   localparam logic [1:0] ERR_PAR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } dec_state_e;

   function automatic logic code_valid(input logic [3:0] code);
      return (code >= DAC_CODE_MIN) && (code <= DAC_CODE_MAX);
   endfunction

   function automatic logic [2:0] code_to_addr(input logic [3:0] code);
      return 3'(code - 4'(DAC_ADDR_OFFSET));
   endfunction

endpackage

// File: rtl/dac_cmd_decoder_if.sv
// Serial command link and shadow-bank read/write-status signals of the DAC command decoder.
// master = link driver / slow control, slave = decoder.
interface dac_cmd_decoder_if #(
   parameter int DATA_W = 10
);
   logic              frame_n;
   logic              bit_en;
   logic              sdin;
   logic [2:0]        rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_valid;
   logic [2:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              err;
   logic [1:0]        err_code;

   modport master (
      output frame_n, bit_en, sdin, rd_addr,
      input  rd_data, wr_valid, wr_addr, wr_data, err, err_code
   );

   modport slave (
      input  frame_n, bit_en, sdin, rd_addr,
      output rd_data, wr_valid, wr_addr, wr_data, err, err_code
   );
endinterface

// File: rtl/dac_frame_shifter.sv
// Frame deserializer: shift register, saturating bit counter, overlong flag and running parity.
// clear_i empties it; a bit strobed in the same cycle becomes the first bit of the new frame.
module dac_frame_shifter
   import dac_link_pkg::*;
#(
   parameter int LEN = DAC_FRAME_LEN
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear_i,
   input  logic           shift_i,
   input  logic           sdin_i,
   output logic [LEN-1:0] shreg_o,
   output logic [3:0]     count_o,
   output logic           overlong_o,
   output logic           parity_o
);

   localparam logic [3:0] LEN_C = 4'(LEN);

   logic [LEN-1:0] shreg_q, shreg_d;
   logic [3:0]     count_q, count_d;
   logic           over_q, over_d;
   logic           par_q, par_d;

   always_comb begin
      shreg_d = clear_i ? '0   : shreg_q;
      count_d = clear_i ? '0   : count_q;
      over_d  = clear_i ? 1'b0 : over_q;
      par_d   = clear_i ? 1'b0 : par_q;
      if (shift_i) begin
         // Bits past the frame length are dropped but still flag the frame as overlong.
         if (count_d < LEN_C) begin
            shreg_d = {shreg_d[LEN-2:0], sdin_i};
            par_d   = par_d ^ sdin_i;
         end else begin
            over_d = 1'b1;
         end
         if (count_d != 4'hF) begin
            count_d = count_d + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q <= '0;
         count_q <= '0;
         over_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         count_q <= count_d;
         over_q  <= over_d;
         par_q   <= par_d;
      end
   end

   assign shreg_o    = shreg_q;
   assign count_o    = count_q;
   assign overlong_o = over_q;
   assign parity_o   = par_q;

endmodule

// File: rtl/dac_cmd_decoder.sv
// DAC link receiver: frame FSM, command-code decode and 8-entry shadow register bank.
// Build option DAC_DEC_PARITY_EN enables the trailing even-parity bit and its check.
module dac_cmd_decoder
   import dac_link_pkg::*;
#(
   parameter int DATA_W = DAC_DATA_W,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              reset,
   dac_cmd_decoder_if.slave  bus
);

   dec_state_e state_q, state_d;

   logic                     qual_bit;
   logic                     clear;
   logic                     shift;
   logic [DAC_FRAME_LEN-1:0] frame;
   logic [3:0]               count;
   logic                     overlong;
   logic                     parity;

   logic [3:0]               code;
   logic [DATA_W-1:0]        data;
   logic [2:0]               addr;
   logic                     len_ok;
   logic                     par_ok;

   logic                     wr_en;
   logic                     wr_valid;
   logic                     err;
   logic [1:0]               err_code_q, err_code_d;
   logic [2:0]               wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]        wr_data_q, wr_data_d;
   logic [NREG-1:0]          we;
   logic [DATA_W-1:0]        shadow_q [NREG];

   assign qual_bit = bus.bit_en & ~bus.frame_n;

   dac_frame_shifter #(
      .LEN (DAC_FRAME_LEN)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (clear),
      .shift_i    (shift),
      .sdin_i     (bus.sdin),
      .shreg_o    (frame),
      .count_o    (count),
      .overlong_o (overlong),
      .parity_o   (parity)
   );

   assign code   = frame[DAC_FRAME_LEN-1 -: 4];
   assign data   = frame[DAC_PAR_BITS +: DATA_W];
   assign addr   = code_to_addr(code);
   assign len_ok = (count == 4'(DAC_FRAME_LEN)) && !overlong;

`ifdef DAC_DEC_PARITY_EN
   // Even parity over all stored bits, parity bit included, must come out zero.
   logic unused_par_bit;
   assign unused_par_bit = frame[0];
   assign par_ok         = ~parity;
`else
   logic unused_parity;
   assign unused_parity = parity;
   assign par_ok        = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      clear      = 1'b0;
      shift      = 1'b0;
      wr_en      = 1'b0;
      wr_valid   = 1'b0;
      err        = 1'b0;
      err_code_d = err_code_q;
      case (state_q)
         ST_IDLE: begin
            clear = 1'b1;
            shift = qual_bit;
            if (!bus.frame_n) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift = qual_bit;
            if (bus.frame_n) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // Always back through IDLE, so strobes seen here are discarded.
            state_d = ST_IDLE;
            if (!len_ok) begin
               err        = 1'b1;
               err_code_d = ERR_LEN;
            end else if (!code_valid(code)) begin
               err        = 1'b1;
               err_code_d = ERR_CODE;
            end else if (!par_ok) begin
               err        = 1'b1;
               err_code_d = ERR_PAR;
            end else begin
               wr_en    = 1'b1;
               wr_valid = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wr_addr_d = wr_en ? addr : wr_addr_q;
   assign wr_data_d = wr_en ? data : wr_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         err_code_q <= ERR_NONE;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         err_code_q <= err_code_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   for (genvar gi = 0; gi < NREG; gi++) begin : g_we
      assign we[gi] = wr_en && (addr == 3'(gi));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we[i]) begin
               shadow_q[i] <= data;
            end
         end
      end
   end

   assign bus.rd_data  = shadow_q[bus.rd_addr];
   assign bus.wr_valid = wr_valid;
   assign bus.err      = err;
   assign bus.err_code = err_code_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_dac_cmd_decoder.sv
// Directed bench for dac_cmd_decoder: table of frames plus hand-written gap and reset sequences.
// Expectations follow DAC_DEC_PARITY_EN when the build defines it.
module tb_dac_cmd_decoder;

`ifdef DAC_DEC_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   typedef struct {
      logic [15:0] vec;
      int          nbits;
      logic        exp_v;
      logic [1:0]  exp_ec;
      logic [2:0]  addr;
      logic [9:0]  data;
      string       name;
   } vec_t;

   localparam int NV = 17;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   vec_t       tbl [NV];
   logic [9:0] sh [8];
   logic [2:0] last_a;
   logic [9:0] last_d;
   logic [1:0] last_ec;
   logic       v, e;
   logic [9:0] rd_old;
   vec_t       tmp;

   dac_cmd_decoder_if #(.DATA_W(10)) bus ();

   dac_cmd_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   function automatic vec_t mk_good(input logic [3:0] code, input logic [9:0] data, input string nm);
      vec_t r;
      logic p;
      p       = ^{code, data};
      r.vec   = (PAR == 1) ? {1'b0, code, data, p} : {2'b00, code, data};
      r.nbits = 14 + PAR;
      r.exp_v = 1'b1;
      r.exp_ec = 2'b00;
      r.addr  = 3'(code - 4'd2);
      r.data  = data;
      r.name  = nm;
      return r;
   endfunction

   function automatic vec_t mk_bad(input logic [15:0] vec, input int n, input logic [1:0] ec,
                                   input logic [2:0] probe, input string nm);
      vec_t r;
      r.vec    = vec;
      r.nbits  = n;
      r.exp_v  = 1'b0;
      r.exp_ec = ec;
      r.addr   = probe;
      r.data   = '0;
      r.name   = nm;
      return r;
   endfunction

   task automatic send_bits(input logic [15:0] vec, input int n);
      if (n == 0) begin
         @(posedge clk); #1;
         bus.frame_n = 1'b0;
         bus.bit_en  = 1'b0;
      end else begin
         for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk); #1;
            bus.frame_n = 1'b0;
            bus.bit_en  = 1'b1;
            bus.sdin    = vec[i];
         end
      end
   endtask

   // Raises frame_n, samples the CHECK cycle; fast=1 drops frame_n again during CHECK with a stray strobe.
   task automatic end_frame(input logic fast, output logic ov, output logic oe, output logic [9:0] ord);
      @(posedge clk); #1;
      bus.frame_n = 1'b1;
      bus.bit_en  = 1'b0;
      @(posedge clk); #1;
      if (fast) begin
         bus.frame_n = 1'b0;
         bus.bit_en  = 1'b1;
         bus.sdin    = 1'b1;
      end
      @(negedge clk);
      ov  = bus.wr_valid;
      oe  = bus.err;
      ord = bus.rd_data;
      chk("exclusive valid/err", 32'(ov & oe), 32'd0);
      if (!fast) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic post_checks(input string nm, input logic [2:0] probe);
      chk({nm, " wr_valid pulse ends"}, 32'(bus.wr_valid), 32'd0);
      chk({nm, " err pulse ends"}, 32'(bus.err), 32'd0);
      chk({nm, " err_code"}, 32'(bus.err_code), 32'(last_ec));
      chk({nm, " wr_addr"}, 32'(bus.wr_addr), 32'(last_a));
      chk({nm, " wr_data"}, 32'(bus.wr_data), 32'(last_d));
      bus.rd_addr = probe;
      #1;
      chk({nm, " rd_data"}, 32'(bus.rd_data), 32'(sh[probe]));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 8; i++) sh[i] = '0;
      last_a  = '0;
      last_d  = '0;
      last_ec = 2'b00;

      tbl[0]  = mk_good(4'h2, 10'h001, "code2 data001");
      tbl[1]  = mk_good(4'h2, 10'h3FF, "code2 data3FF");
      tbl[2]  = mk_good(4'h3, 10'h155, "code3 data155");
      tbl[3]  = mk_good(4'h4, 10'h2AA, "code4 data2AA");
      tbl[4]  = mk_good(4'h5, 10'h0F0, "code5 data0F0");
      tbl[5]  = mk_good(4'h6, 10'h30F, "code6 data30F");
      tbl[6]  = mk_good(4'h7, 10'h001, "code7 data001");
      tbl[7]  = mk_good(4'h8, 10'h200, "code8 data200");
      tbl[8]  = mk_good(4'h9, 10'h123, "code9 data123");
      tmp     = mk_good(4'hA, 10'h0AB, "");
      tbl[9]  = mk_bad(tmp.vec, tmp.nbits, 2'b10, 3'd0, "bad code A");
      tmp     = mk_good(4'h0, 10'h3C3, "");
      tbl[10] = mk_bad(tmp.vec, tmp.nbits, 2'b10, 3'd1, "bad code 0");
      tmp     = mk_good(4'hF, 10'h011, "");
      tbl[11] = mk_bad(tmp.vec, tmp.nbits, 2'b10, 3'd7, "bad code F");
      tbl[12] = mk_bad({3'b000, 4'h4, 9'h0F8}, 13, 2'b01, 3'd2, "13-bit frame");
      tbl[13] = mk_bad({4'h6, 10'h2A5, 2'b01}, 16, 2'b01, 3'd4, "16-bit frame");
      tbl[14] = mk_bad(16'h0000, 0, 2'b01, 3'd5, "zero-bit frame");
`ifdef DAC_DEC_PARITY_EN
      tbl[15] = mk_bad({1'b0, 4'h3, 10'h155, 1'b0}, 15, 2'b11, 3'd1, "15-bit flipped parity");
`else
      tbl[15] = mk_bad({1'b0, 4'h3, 10'h155, 1'b1}, 15, 2'b01, 3'd1, "15-bit frame");
`endif
      tbl[16] = mk_good(4'h5, 10'h0CC, "code5 data0CC");

      reset       = 1'b0;
      bus.frame_n = 1'b1;
      bus.bit_en  = 1'b0;
      bus.sdin    = 1'b0;
      bus.rd_addr = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset wr_valid", 32'(bus.wr_valid), 32'd0);
      chk("reset err", 32'(bus.err), 32'd0);
      chk("reset err_code", 32'(bus.err_code), 32'd0);
      chk("reset wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("reset wr_data", 32'(bus.wr_data), 32'd0);
      chk("reset rd_data", 32'(bus.rd_data), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         bus.rd_addr = tbl[i].addr;
         send_bits(tbl[i].vec, tbl[i].nbits);
         end_frame(1'b0, v, e, rd_old);
         chk({tbl[i].name, " wr_valid"}, 32'(v), 32'(tbl[i].exp_v));
         chk({tbl[i].name, " err"}, 32'(e), 32'(!tbl[i].exp_v));
         chk({tbl[i].name, " rd_data old in CHECK"}, 32'(rd_old), 32'(sh[tbl[i].addr]));
         if (tbl[i].exp_v) begin
            sh[tbl[i].addr] = tbl[i].data;
            last_a          = tbl[i].addr;
            last_d          = tbl[i].data;
         end else begin
            last_ec = tbl[i].exp_ec;
         end
         post_checks(tbl[i].name, tbl[i].addr);
      end

      for (int a = 0; a < 8; a++) begin
         bus.rd_addr = 3'(a);
         #1;
         chk($sformatf("bank shadow[%0d]", a), 32'(bus.rd_data), 32'(sh[a]));
      end

      // 13-bit frame, then a good frame after a single frame_n high cycle
      send_bits({3'b000, 4'h7, 9'h155}, 13);
      end_frame(1'b1, v, e, rd_old);
      chk("gap: short frame err", 32'(e), 32'd1);
      chk("gap: short frame wr_valid", 32'(v), 32'd0);
      last_ec = 2'b01;
      tmp = mk_good(4'h8, 10'h2DB, "gap: next frame");
      bus.rd_addr = tmp.addr;
      send_bits(tmp.vec, tmp.nbits);
      end_frame(1'b0, v, e, rd_old);
      chk("gap: next frame wr_valid", 32'(v), 32'd1);
      chk("gap: next frame err", 32'(e), 32'd0);
      sh[tmp.addr] = tmp.data;
      last_a       = tmp.addr;
      last_d       = tmp.data;
      post_checks(tmp.name, tmp.addr);

      // reset in the middle of a frame
      tmp = mk_good(4'h7, 10'h3A5, "");
      for (int i = tmp.nbits - 1; i >= tmp.nbits - 7; i--) begin
         @(posedge clk); #1;
         bus.frame_n = 1'b0;
         bus.bit_en  = 1'b1;
         bus.sdin    = tmp.vec[i];
      end
      #2;
      reset = 1'b0;
      #1;
      chk("mid reset wr_valid", 32'(bus.wr_valid), 32'd0);
      chk("mid reset err", 32'(bus.err), 32'd0);
      chk("mid reset err_code", 32'(bus.err_code), 32'd0);
      chk("mid reset wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("mid reset wr_data", 32'(bus.wr_data), 32'd0);
      for (int a = 0; a < 8; a++) begin
         bus.rd_addr = 3'(a);
         #1;
         chk($sformatf("mid reset shadow[%0d]", a), 32'(bus.rd_data), 32'd0);
         sh[a] = '0;
      end
      bus.frame_n = 1'b1;
      bus.bit_en  = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      last_a  = '0;
      last_d  = '0;
      last_ec = 2'b00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("after reset no pulse", 32'(bus.wr_valid | bus.err), 32'd0);
      end
      tmp = mk_good(4'h9, 10'h3A5, "after reset frame");
      bus.rd_addr = tmp.addr;
      send_bits(tmp.vec, tmp.nbits);
      end_frame(1'b0, v, e, rd_old);
      chk("after reset frame wr_valid", 32'(v), 32'd1);
      chk("after reset frame err", 32'(e), 32'd0);
      sh[tmp.addr] = tmp.data;
      last_a       = tmp.addr;
      last_d       = tmp.data;
      post_checks(tmp.name, tmp.addr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
